// File: rtl/jacobi_pkg.sv
// Shared state codes, stage count and helpers for the Jacobi eigen-decomposition sequencer.
package jacobi_pkg;

    localparam int NUM_STAGES = 9;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE    = 4'd0;
    localparam state_t ST_COV     = 4'd1;
    localparam state_t ST_MUX     = 4'd2;
    localparam state_t ST_ROTATE  = 4'd3;
    localparam state_t ST_K       = 4'd4;
    localparam state_t ST_MAX     = 4'd5;
    localparam state_t ST_THETA   = 4'd6;
    localparam state_t ST_S       = 4'd7;
    localparam state_t ST_COUNTER = 4'd8;
    localparam state_t ST_ETME    = 4'd9;
    localparam state_t ST_DONE    = 4'd10;
    localparam state_t ST_ERR     = 4'd11;

    function automatic logic is_stage(input state_t s);
        return (s >= ST_COV) && (s <= ST_ETME);
    endfunction

    // Stage state s maps to bit s-1 of the start/done vectors.
    function automatic logic [NUM_STAGES-1:0] stage_onehot(input state_t s);
        logic [NUM_STAGES-1:0] oh;
        oh = '0;
        if (is_stage(s)) oh[s - ST_COV] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/jacobi_sequencer_if.sv
// Handshake bundle between the Jacobi sequencer (master) and its run controller / stage units (slave).
interface jacobi_sequencer_if #(parameter int ITER_W = 3);
    import jacobi_pkg::*;

    logic                  start;
    logic                  abort;
    logic [NUM_STAGES-1:0] stage_done;
    logic                  converged;
    logic [NUM_STAGES-1:0] stage_start;
    state_t                state;
    logic [ITER_W-1:0]     iteration_cnt;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        input  start, abort, stage_done, converged,
        output stage_start, state, iteration_cnt, busy, done, error
    );

    modport slave (
        output start, abort, stage_done, converged,
        input  stage_start, state, iteration_cnt, busy, done, error
    );

endinterface

// File: rtl/jacobi_wdog.sv
// Per-stage watchdog: clearable up-counter that parks at its terminal count WDOG_CYCLES-1.
module jacobi_wdog #(
    parameter int WDOG_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int              CNT_W = $clog2(WDOG_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WDOG_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tc = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/jacobi_sequencer.sv
// Start/done sequencer for the nine Jacobi stage units, looping mux..ETME until MAX_ITER or convergence.
// Define JACOBI_SEQ_WDOG_EN to add the per-stage watchdog and the ERR state.
module jacobi_sequencer
    import jacobi_pkg::*;
#(
    parameter int MAX_ITER    = 5,
    parameter int ITER_W      = 3,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    jacobi_sequencer_if.master  bus
);

    localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

    state_t                state_q, state_d;
    logic [NUM_STAGES-1:0] stage_start_q, stage_start_d;
    logic [ITER_W-1:0]     iter_q, iter_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic                  active_done;
    logic [ITER_W-1:0]     iter_inc;
    logic                  wdog_tc;

    // A stage's start pulse is only high in its entry cycle, so it doubles as the entry marker.
    assign active_done = (|(bus.stage_done & stage_onehot(state_q))) && !(|stage_start_q);
    assign iter_inc    = (iter_q == MAX_CNT) ? iter_q : iter_q + 1'b1;

`ifdef JACOBI_SEQ_WDOG_EN
    jacobi_wdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clk (clk),
        .rst (rst),
        .clr (state_d != state_q),
        .en  (is_stage(state_q)),
        .tc  (wdog_tc)
    );
`else
    assign wdog_tc = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d = state_q;
        iter_d  = iter_q;
        error_d = error_q;

        if (is_stage(state_q)) begin
            if (bus.abort) begin
                state_d = ST_IDLE;
            end else if (active_done) begin
                if (state_q == ST_ETME) begin
                    iter_d  = iter_inc;
                    state_d = (iter_inc == MAX_CNT || bus.converged) ? ST_DONE : ST_MUX;
                end else begin
                    state_d = state_q + 4'd1;
                end
            end else if (wdog_tc) begin
                state_d = ST_ERR;
                error_d = 1'b1;
            end
        end else if (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR) begin
            if (bus.start) begin
                state_d = ST_COV;
                iter_d  = '0;
                error_d = 1'b0;
            end else if (state_q == ST_DONE) begin
                state_d = ST_IDLE;
            end
        end else begin
            state_d = ST_IDLE;
        end

        // Every transition lands in a different state, so a change of state is a stage entry.
        stage_start_d = (state_d != state_q) ? stage_onehot(state_d) : '0;
        busy_d        = is_stage(state_d);
        done_d        = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
        if (rst) begin
            state_q       <= ST_IDLE;
            stage_start_q <= '0;
            iter_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            stage_start_q <= stage_start_d;
            iter_q        <= iter_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    assign bus.state         = state_q;
    assign bus.stage_start   = stage_start_q;
    assign bus.iteration_cnt = iter_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.error         = error_q;

    a_cfg_legal: assert property (@(posedge clk)
        (MAX_ITER >= 1) && (MAX_ITER < (1 << ITER_W)) && (WDOG_CYCLES >= 2));

endmodule
